// File: rtl/identity_sweeper_pkg.sv
// identity_sweeper_pkg: shared FSM state encoding and dwell-counter width helper for identity_sweeper
package identity_sweeper_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  function automatic int dwell_w(input int dwell);
    return dwell > 1 ? $clog2(dwell) : 1;
  endfunction
endpackage

// File: rtl/identity_sweeper_sweep_counter.sv
// sweep_counter: dwell counter plus ascending vector counter that holds on its last vector
module sweep_counter
  import identity_sweeper_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int DWELL = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [N_IN-1:0] vec,
  output logic            sample_pulse,
  output logic            last_vec
);
  localparam int CW = dwell_w(DWELL);
  logic [CW-1:0] cnt;
  assign sample_pulse = cnt == CW'(DWELL - 1);
  assign last_vec     = &vec;
  // dwell count wraps on the sample cycle, which is also when the vector advances
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      vec <= '0;
    end else if (en) begin
      cnt <= sample_pulse ? '0 : cnt + CW'(1);
      if (sample_pulse && !last_vec) vec <= vec + N_IN'(1);
    end
  end
endmodule

// File: rtl/identity_sweeper.sv
// identity_sweeper: exhaustive truth-table sweep comparing lhs/rhs; STOP_ON_FIRST_ERR_EN halts on the first mismatch
module identity_sweeper
  import identity_sweeper_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int DWELL = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            lhs_in,
  input  logic            rhs_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);
`ifdef STOP_ON_FIRST_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  state_t state;
  logic sample_pulse, last_vec, sample, mism, stop_now, clr, en;
  assign mism     = lhs_in ^ rhs_in;
  assign sample   = sample_pulse && state == ST_SWEEP;
  assign stop_now = STOP && sample && mism;
  assign clr      = state != ST_SWEEP && start;
  assign en       = state == ST_SWEEP && !stop_now;
  sweep_counter #(.N_IN(N_IN), .DWELL(DWELL)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .en           (en),
    .vec          (vec_out),
    .sample_pulse (sample_pulse),
    .last_vec     (last_vec)
  );
  // sweep control and result capture; a stop freezes the counter so the failing vector stays applied
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (state != ST_SWEEP) begin
      if (start) begin
        state           <= ST_SWEEP;
        busy            <= 1'b1;
        done            <= 1'b0;
        pass            <= 1'b0;
        err_count       <= '0;
        first_err_vec   <= '0;
        first_err_valid <= 1'b0;
      end
    end else if (sample) begin
      if (mism) begin
        err_count <= err_count + (N_IN+1)'(1);
        if (!first_err_valid) begin
          first_err_vec   <= vec_out;
          first_err_valid <= 1'b1;
        end
      end
      if (last_vec || stop_now) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= err_count == '0 && !mism;
      end
    end
  end
endmodule

// File: tb/tb_identity_sweeper.sv
// tb_identity_sweeper: table-driven scoreboard bench for identity_sweeper (N_IN=3/DWELL=20 and N_IN=4/DWELL=1)
module tb_identity_sweeper;
  logic clk = 1'b0, rst = 1'b1, start3 = 1'b0, start4 = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] vec3, fev3;
  logic [3:0] err3;
  logic lhs3, rhs3, id3, busy3, done3, pass3, fevld3;
  logic [3:0] vec4, fev4;
  logic [4:0] err4;
  logic lhs4, rhs4, busy4, done4, pass4, fevld4;
  int m3 = 0, m4 = 0;
  assign lhs3 = vec3[2] & (vec3[1] | vec3[0]);
  assign id3  = (vec3[2] & vec3[1]) | (vec3[2] & vec3[0]);
  assign rhs3 = m3 == 1 ? lhs3 ^ (vec3 == 3'b101) :
                m3 == 2 ? ~lhs3 :
                m3 == 3 ? lhs3 ^ (vec3 == 3'b010 || vec3 == 3'b110) : id3;
  assign lhs4 = (vec4[3] ^ vec4[2]) ^ (vec4[1] ^ vec4[0]);
  assign rhs4 = m4 == 1 ? ~lhs4 : vec4[3] ^ (vec4[2] ^ (vec4[1] ^ vec4[0]));

  identity_sweeper #(.N_IN(3), .DWELL(20)) d3 (
    .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .lhs_in(lhs3), .rhs_in(rhs3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_vec(fev3), .first_err_valid(fevld3));
  identity_sweeper #(.N_IN(4), .DWELL(1)) d4 (
    .clk(clk), .rst(rst), .start(start4), .vec_out(vec4), .lhs_in(lhs4), .rhs_in(rhs4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_vec(fev4), .first_err_valid(fevld4));

  typedef struct {
    int mode; int noise; int cycles; int err; int fev; int fevld; int pass; int vec;
  } rec_t;
  rec_t tbl[5];
  rec_t sbq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run3(input rec_t r);
    rec_t e;
    int cyc;
    m3 = r.mode;
    sbq.push_back(r);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("d3 busy after start", busy3, 1);
    chk("d3 done cleared", done3, 0);
    chk("d3 err cleared", err3, 0);
    chk("d3 fevld cleared", fevld3, 0);
    cyc = 0;
    while (cyc < 400 && !done3) begin
      @(posedge clk); #1;
      cyc++;
      if (!done3) start3 = (r.noise != 0) && (cyc % 50 == 10);
    end
    start3 = 1'b0;
    chk("d3 done within bound", done3, 1);
    e = sbq.pop_front();
    chk("d3 cycles", cyc, e.cycles);
    chk("d3 err_count", err3, e.err);
    chk("d3 first_err_vec", fev3, e.fev);
    chk("d3 first_err_valid", fevld3, e.fevld);
    chk("d3 pass", pass3, e.pass);
    chk("d3 vec_out", vec3, e.vec);
    chk("d3 busy at done", busy3, 0);
  endtask

  task automatic run4(input int mode, input int cycles, input int err, input int pass, input int vfin, input bit step);
    int cyc;
    m4 = mode;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("d4 busy after start", busy4, 1);
    chk("d4 done cleared", done4, 0);
    chk("d4 pass cleared", pass4, 0);
    chk("d4 err cleared", err4, 0);
    chk("d4 vec restart", vec4, 0);
    cyc = 0;
    while (cyc < 100 && !done4) begin
      @(posedge clk); #1;
      cyc++;
      if (step) chk("d4 vec step", vec4, cyc < 16 ? cyc : 15);
    end
    chk("d4 done within bound", done4, 1);
    chk("d4 cycles", cyc, cycles);
    chk("d4 err_count", err4, err);
    chk("d4 pass", pass4, pass);
    chk("d4 vec_out", vec4, vfin);
  endtask

  initial begin
`ifdef STOP_ON_FIRST_ERR_EN
    tbl[0] = '{0, 0, 160, 0, 0, 0, 1, 7};
    tbl[1] = '{1, 0, 120, 1, 5, 1, 0, 5};
    tbl[2] = '{2, 0,  20, 1, 0, 1, 0, 0};
    tbl[3] = '{3, 0,  60, 1, 2, 1, 0, 2};
    tbl[4] = '{0, 1, 160, 0, 0, 0, 1, 7};
`else
    tbl[0] = '{0, 0, 160, 0, 0, 0, 1, 7};
    tbl[1] = '{1, 0, 160, 1, 5, 1, 0, 7};
    tbl[2] = '{2, 0, 160, 8, 0, 1, 0, 7};
    tbl[3] = '{3, 0, 160, 2, 2, 1, 0, 7};
    tbl[4] = '{0, 1, 160, 0, 0, 0, 1, 7};
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset vec", vec3, 0);
    chk("reset busy", busy3, 0);
    chk("reset done", done3, 0);
    chk("reset pass", pass3, 0);
    chk("reset err", err3, 0);
    chk("reset fevld", fevld3, 0);
    m3 = 0;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (85) @(posedge clk);
    #1;
    chk("mid-sweep vec", vec3, 4);
    chk("mid-sweep busy", busy3, 1);
    rst = 1'b1;
    start3 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start3 = 1'b0;
    chk("rst mid vec", vec3, 0);
    chk("rst mid busy", busy3, 0);
    chk("rst mid done", done3, 0);
    chk("rst mid err", err3, 0);
    chk("rst mid fev", fev3, 0);
    chk("rst mid fevld", fevld3, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle hold vec", vec3, 0);
    chk("idle hold busy", busy3, 0);
    for (int i = 0; i < 5; i++) run3(tbl[i]);
    run4(0, 16, 0, 1, 15, 1'b1);
`ifdef STOP_ON_FIRST_ERR_EN
    run4(1, 1, 1, 0, 0, 1'b0);
`else
    run4(1, 16, 16, 0, 15, 1'b0);
`endif
    run4(0, 16, 0, 1, 15, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
